// File: rtl/input_conditioner.sv
// Synchronises and debounces the raw push-button and run/step mode switch for the clock generator.
// Define AUTO_REPEAT_EN to add hold-to-repeat press pulses on the button channel.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          MODE_ACTIVE_LOW = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_PERIOD   = 2700000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic mode_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic mode_level,
  output logic mode_changed
);

  localparam int unsigned CntW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit          SingleCycle = (DEBOUNCE_CYCLES == 1);
  // A CHK state is entered on the first differing sample, so it accepts after D-2 increments.
  localparam int unsigned CntLastInt = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(CntLastInt);

  typedef enum logic [1:0] {StStableLo, StChkHi, StStableHi, StChkLo} chan_state_e;

  // Channel 0 is the button, channel 1 the mode switch.
  logic [1:0]      raw_act;
  logic [1:0]      sync1_q, sync_q;
  logic [1:0]      level_q, rise_q, fall_q;
  logic [1:0]      accept;
  chan_state_e     state_q [2];
  logic [CntW-1:0] cnt_q   [2];
  logic            rep_pulse;

  assign raw_act = {mode_raw ^ MODE_ACTIVE_LOW, btn_raw ^ BTN_ACTIVE_LOW};

  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        StStableLo: accept[i] = SingleCycle && sync_q[i];
        StChkHi:    accept[i] = sync_q[i] && (cnt_q[i] == CntLast);
        StStableHi: accept[i] = SingleCycle && !sync_q[i];
        StChkLo:    accept[i] = !sync_q[i] && (cnt_q[i] == CntLast);
        default:    accept[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StStableLo;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= raw_act;
      sync_q  <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        case (state_q[i])
          StStableLo, StChkHi: begin
            if (accept[i]) begin
              state_q[i] <= StStableHi;
              level_q[i] <= 1'b1;
              rise_q[i]  <= 1'b1;
            end else if (!sync_q[i]) begin
              state_q[i] <= StStableLo;
            end else if (state_q[i] == StStableLo) begin
              state_q[i] <= StChkHi;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
          end
          StStableHi, StChkLo: begin
            if (accept[i]) begin
              state_q[i] <= StStableLo;
              level_q[i] <= 1'b0;
              fall_q[i]  <= 1'b1;
            end else if (sync_q[i]) begin
              state_q[i] <= StStableHi;
            end else if (state_q[i] == StStableHi) begin
              state_q[i] <= StChkLo;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
          end
          default: state_q[i] <= StStableLo;
        endcase
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_pulse_q;

  // Down-counter reloaded while released; a press that is being released this cycle never repeats.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_pulse_q <= 1'b0;
      if (!level_q[0] || accept[0]) begin
        rep_cnt_q <= RepW'(REPEAT_DELAY - 1);
      end else if (rep_cnt_q == '0) begin
        rep_pulse_q <= 1'b1;
        rep_cnt_q   <= RepW'(REPEAT_PERIOD - 1);
      end else begin
        rep_cnt_q <= rep_cnt_q - RepW'(1);
      end
    end
  end

  assign rep_pulse = rep_pulse_q;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_pulse = 1'b0;
`endif

  assign btn_level    = level_q[0];
  assign btn_press    = rise_q[0] | rep_pulse;
  assign btn_release  = fall_q[0];
  assign mode_level   = level_q[1];
  assign mode_changed = rise_q[1] | fall_q[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random bouncy inputs
// compared every cycle against a run-length reference model.
module tb_input_conditioner;

  localparam int unsigned Deb       = 4;
  localparam int unsigned RepDelay  = 10;
  localparam int unsigned RepPeriod = 5;

  logic sys_clk  = 1'b0;
  logic rst_n    = 1'b0;
  logic btn_raw  = 1'b1;
  logic mode_raw = 1'b0;
  logic btn_level, btn_press, btn_release, mode_level, mode_changed;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw samples seen two edges late, level flips after Deb differing samples.
  bit m_hist  [2][$];
  int m_run   [2];
  bit m_level [2];
  bit m_rise  [2];
  bit m_fall  [2];
  bit m_press;
  int m_hold;

  input_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .BTN_ACTIVE_LOW  (1'b1),
    .MODE_ACTIVE_LOW (1'b0),
    .REPEAT_DELAY    (RepDelay),
    .REPEAT_PERIOD   (RepPeriod)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .mode_raw     (mode_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .mode_level   (mode_level),
    .mode_changed (mode_changed)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hist[i].delete();
      m_hist[i].push_back(1'b0);
      m_hist[i].push_back(1'b0);
      m_run[i]   = 0;
      m_level[i] = 1'b0;
      m_rise[i]  = 1'b0;
      m_fall[i]  = 1'b0;
    end
    m_press = 1'b0;
    m_hold  = 0;
  endtask

  task automatic model_step();
    bit act [2];
    bit s;
    act[0] = ~btn_raw;
    act[1] = mode_raw;
    for (int i = 0; i < 2; i++) begin
      s = m_hist[i].pop_front();
      m_hist[i].push_back(act[i]);
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (s != m_level[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == int'(Deb)) begin
        m_level[i] = s;
        m_run[i]   = 0;
        if (s) m_rise[i] = 1'b1;
        else m_fall[i] = 1'b1;
      end
    end
    m_press = m_rise[0];
`ifdef AUTO_REPEAT_EN
    if (m_rise[0]) begin
      m_hold = 0;
    end else if (m_level[0]) begin
      m_hold++;
      if (m_hold >= int'(RepDelay) && (m_hold - int'(RepDelay)) % int'(RepPeriod) == 0)
        m_press = 1'b1;
    end
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".btn_level"}, btn_level, m_level[0]);
    check({tag, ".btn_press"}, btn_press, m_press);
    check({tag, ".btn_release"}, btn_release, m_fall[0]);
    check({tag, ".mode_level"}, mode_level, m_level[1]);
    check({tag, ".mode_changed"}, mode_changed, m_rise[1] | m_fall[1]);
    check({tag, ".press_release_excl"}, btn_press & btn_release, 0);
  endtask

  // Drive inputs just after an edge, advance one cycle, then compare.
  task automatic cycle(input bit b, input bit m, input string tag);
    btn_raw  = b;
    mode_raw = m;
    @(posedge sys_clk);
    if (rst_n) model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run_lat(input bit b, input bit m, input string tag,
                         output int lat_btn, output int lat_mode);
    lat_btn  = 0;
    lat_mode = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(b, m, tag);
      if (lat_btn == 0 && (btn_press || btn_release)) lat_btn = k;
      if (lat_mode == 0 && mode_changed) lat_mode = k;
    end
  endtask

  initial begin
    int lb, lm;
    bit rb, rm;
    model_reset();
    #1;
    check_all("in_reset");
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, "idle");

    run_lat(1'b0, 1'b0, "press", lb, lm);
    check("press_latency", lb, 6);
    check("press_level", btn_level, 1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, "release1");
    run_lat(1'b1, 1'b0, "release1_settle", lb, lm);

    // Bounce: low for 3 cycles, high for 2, five times.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, "bounce_lo");
      for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, "bounce_hi");
    end
    check("bounce_level", btn_level, 0);
    run_lat(1'b0, 1'b0, "press2", lb, lm);
    check("press2_latency", lb, 6);

    // Release the button and switch mode together.
    run_lat(1'b1, 1'b1, "rel_mode", lb, lm);
    check("release_latency", lb, 6);
    check("mode_latency", lm, 6);
    check("mode_level_set", mode_level, 1);

    // Reset mid-count: button held low until the count reaches 2.
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    for (int k = 0; k < 2; k++) begin
      @(posedge sys_clk);
      #1;
      check_all("rst_hold");
    end
    rst_n = 1'b1;
    run_lat(1'b0, 1'b1, "post_rst", lb, lm);
    check("post_rst_press_latency", lb, 6);
    check("post_rst_mode_latency", lm, 6);

    // Random runs of 1..8 cycles exercise both bounces and accepted changes.
    rb = 1'b0;
    rm = 1'b1;
    for (int blk = 0; blk < 150; blk++) begin
      int len;
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) rb = ~rb;
      if ($urandom_range(0, 2) == 0) rm = ~rm;
      for (int k = 0; k < len; k++) cycle(rb, rm, "rand");
    end

`ifdef AUTO_REPEAT_EN
    begin
      int hits [$];
      for (int k = 0; k < 14; k++) cycle(1'b1, rm, "rep_idle");
      for (int k = 1; k <= 45; k++) begin
        cycle((k <= 28) ? 1'b0 : 1'b1, rm, "repeat");
        if (btn_press) hits.push_back(k);
      end
      check("repeat_count", hits.size(), 5);
      if (hits.size() == 5) begin
        check("repeat_first", hits[0], 6);
        check("repeat_1", hits[1], 16);
        check("repeat_2", hits[2], 21);
        check("repeat_3", hits[3], 26);
        check("repeat_4", hits[4], 31);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
